set_assoc_lru: RTL and testbench

SET_ASSOC_LRU -- requirements
Module: set_assoc_lru

---
 rtl/set_assoc_lru.sv | 216 +++++++++++++++++++++
 tb/tb_set_assoc_lru.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_lru.sv
// Set-associative tag store with per-set true-LRU ages, dirty tracking and access statistics.
// A power-up sweep clears every set; after that, each access takes LOOKUP then UPDATE.
module set_assoc_lru #(
    parameter int WAYS    = 4,
    parameter int INDEX_W = 11,
    parameter int TAG_W   = 17,
    parameter int CNT_W   = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [TAG_W-1:0]                       req_tag,
    input  logic [INDEX_W-1:0]                     req_index,
    input  logic                                   req_store,
    input  logic                                   stats_clr,
    output logic                                   resp_valid,
    output logic                                   resp_hit,
    output logic                                   resp_evict,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] resp_way,
    output logic [CNT_W-1:0]                       accesses,
    output logic [CNT_W-1:0]                       read_hits,
    output logic [CNT_W-1:0]                       write_hits,
    output logic [CNT_W-1:0]                       read_misses,
    output logic [CNT_W-1:0]                       write_misses,
    output logic [CNT_W-1:0]                       evictions,
    output logic                                   init_done
);

    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AW   = WW;
    localparam int SETS = 1 << INDEX_W;

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_LOOKUP = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    logic [1:0]         state;
    logic [INDEX_W-1:0] init_ptr;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic               store_q;

    logic [WAYS-1:0]  valid_mem [SETS];
    logic [WAYS-1:0]  dirty_mem [SETS];
    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [AW-1:0]    age_mem   [SETS][WAYS];

    logic               hit;
    logic               found_invalid;
    logic               evict;
    logic [WW-1:0]      hit_way;
    logic [WW-1:0]      victim;
    logic [WW-1:0]      target;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    logic [WAYS-1:0]    wr_valid;
    logic [WAYS-1:0]    wr_dirty;
    logic [TAG_W-1:0]   wr_tag [WAYS];
    logic [AW-1:0]      wr_age [WAYS];
    logic [AW-1:0]      old_age;

    assign req_ready = (state == S_IDLE);

    // Lookup: hit detection, then victim choice (first invalid way, else the LRU way).
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        found_invalid = 1'b0;
        victim        = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_mem[idx_q][w] && (tag_mem[idx_q][w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_mem[idx_q][w]) begin
                found_invalid = 1'b1;
                victim        = WW'(w);
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_mem[idx_q][w] == AW'(WAYS - 1)) begin
                    victim = WW'(w);
                end
            end
        end
        target = hit ? hit_way : victim;
        evict  = !hit && valid_mem[idx_q][victim] && dirty_mem[idx_q][victim];
    end

    // Whole-set write data: the INIT sweep pattern, or the LRU/tag update of the target way.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = idx_q;
        wr_valid = valid_mem[idx_q];
        wr_dirty = dirty_mem[idx_q];
        old_age  = age_mem[idx_q][resp_way];
        for (int w = 0; w < WAYS; w++) begin
            wr_tag[w] = tag_mem[idx_q][w];
            wr_age[w] = age_mem[idx_q][w];
        end
        if (state == S_INIT) begin
            wr_en    = 1'b1;
            wr_idx   = init_ptr;
            wr_valid = '0;
            wr_dirty = '0;
            for (int w = 0; w < WAYS; w++) begin
                wr_tag[w] = '0;
                wr_age[w] = AW'(w);
            end
        end else if (state == S_UPDATE) begin
            wr_en = 1'b1;
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == resp_way) begin
                    wr_valid[w] = 1'b1;
                    wr_dirty[w] = store_q | (resp_hit & dirty_mem[idx_q][w]);
                    wr_tag[w]   = tag_q;
                    wr_age[w]   = '0;
                end else if (age_mem[idx_q][w] < old_age) begin
                    wr_age[w] = age_mem[idx_q][w] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_idx] <= wr_valid;
            dirty_mem[wr_idx] <= wr_dirty;
            for (int w = 0; w < WAYS; w++) begin
                tag_mem[wr_idx][w] <= wr_tag[w];
                age_mem[wr_idx][w] <= wr_age[w];
            end
        end
    end

    // Control FSM; the response fields are registered at the end of LOOKUP so they are stable in UPDATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            init_ptr   <= '0;
            init_done  <= 1'b0;
            tag_q      <= '0;
            idx_q      <= '0;
            store_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_evict <= 1'b0;
            resp_way   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == {INDEX_W{1'b1}}) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        tag_q   <= req_tag;
                        idx_q   <= req_index;
                        store_q <= req_store;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= hit;
                    resp_evict <= evict;
                    resp_way   <= target;
                    state      <= S_UPDATE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accesses     <= '0;
            read_hits    <= '0;
            write_hits   <= '0;
            read_misses  <= '0;
            write_misses <= '0;
            evictions    <= '0;
        end else if (stats_clr) begin
            accesses     <= '0;
            read_hits    <= '0;
            write_hits   <= '0;
            read_misses  <= '0;
            write_misses <= '0;
            evictions    <= '0;
        end else if (resp_valid) begin
            accesses <= accesses + CNT_W'(1);
            case ({store_q, resp_hit})
                2'b01:   read_hits    <= read_hits + CNT_W'(1);
                2'b11:   write_hits   <= write_hits + CNT_W'(1);
                2'b00:   read_misses  <= read_misses + CNT_W'(1);
                default: write_misses <= write_misses + CNT_W'(1);
            endcase
            if (resp_evict) begin
                evictions <= evictions + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_lru.sv
// Directed bench for set_assoc_lru: init sweep, hit/miss, LRU victim, dirty eviction,
// statistics clear and reset abandoning an access.
module tb_set_assoc_lru;

    localparam int WAYS    = 4;
    localparam int INDEX_W = 4;
    localparam int TAG_W   = 17;
    localparam int CNT_W   = 32;
    localparam int WW      = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic               req_store;
    logic               stats_clr;
    logic               resp_valid;
    logic               resp_hit;
    logic               resp_evict;
    logic [WW-1:0]      resp_way;
    logic [CNT_W-1:0]   accesses;
    logic [CNT_W-1:0]   read_hits;
    logic [CNT_W-1:0]   write_hits;
    logic [CNT_W-1:0]   read_misses;
    logic [CNT_W-1:0]   write_misses;
    logic [CNT_W-1:0]   evictions;
    logic               init_done;

    int vectorCount = 0;
    int missCount   = 0;

    set_assoc_lru #(
        .WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_index(req_index), .req_store(req_store),
        .stats_clr(stats_clr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_evict(resp_evict), .resp_way(resp_way),
        .accesses(accesses), .read_hits(read_hits), .write_hits(write_hits),
        .read_misses(read_misses), .write_misses(write_misses), .evictions(evictions),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCounters(input string tag, input int acc, input int rh, input int wh,
                                 input int rm, input int wm, input int ev);
        checkOutput({tag, "_accesses"},     accesses,     64'(acc));
        checkOutput({tag, "_read_hits"},    read_hits,    64'(rh));
        checkOutput({tag, "_write_hits"},   write_hits,   64'(wh));
        checkOutput({tag, "_read_misses"},  read_misses,  64'(rm));
        checkOutput({tag, "_write_misses"}, write_misses, 64'(wm));
        checkOutput({tag, "_evictions"},    evictions,    64'(ev));
    endtask

    // Entered and left on a falling edge; optionally raises stats_clr during the response cycle.
    task automatic applyStimulus(input string name, input logic [TAG_W-1:0] tag,
                                 input logic [INDEX_W-1:0] index, input logic store, input logic clr,
                                 input logic exp_hit, input logic exp_evict, input logic [WW-1:0] exp_way);
        int waitCycles;
        waitCycles = 0;
        while (!req_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({name, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_tag   = tag;
        req_index = index;
        req_store = store;
        @(negedge clk);
        req_valid  = 1'b0;
        waitCycles = 1;
        while (!resp_valid && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({name, "_latency"}, waitCycles, 2);
        checkOutput({name, "_hit"},   resp_hit,   exp_hit);
        checkOutput({name, "_evict"}, resp_evict, exp_evict);
        checkOutput({name, "_way"},   resp_way,   exp_way);
        if (clr) stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        checkOutput({name, "_pulse"}, resp_valid, 0);
    endtask

    initial begin
        int  n;
        logic sawResp;
        logic sawReady;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_tag   = '0;
        req_index = '0;
        req_store = 1'b0;
        stats_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_init_done",  init_done,  0);
        checkOutput("rst_req_ready",  req_ready,  0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        rst = 1'b0;

        n = 0;
        while (!init_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("init_cycles", n, 16);
        checkCounters("init", 0, 0, 0, 0, 0, 0);

        applyStimulus("rd_miss", 17'h5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus("rd_hit",  17'h5, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        checkCounters("rd_pair", 2, 1, 0, 1, 0, 0);

        // Set 0: ages go [0,1,2,3] -> [3,2,1,0] after four fills, [0,3,2,1] after reading tag 1.
        for (int i = 0; i < 4; i++) begin
            applyStimulus("wr_fill", 17'(i + 1), 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(i));
        end
        applyStimulus("rd_tag1",   17'h1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus("wr_tag5",   17'h5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        applyStimulus("rd_tag2",   17'h2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        checkCounters("lru_evict", 9, 2, 0, 2, 5, 2);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("rd_fill", 17'(i + 1), 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'(i));
        end
        applyStimulus("rd_clean",  17'h5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus("wr_hit",    17'h5, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        checkCounters("clean_victim", 15, 2, 1, 7, 5, 2);

        applyStimulus("clr_on_resp", 17'h5, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        checkCounters("after_clr", 0, 0, 0, 0, 0, 0);
        applyStimulus("post_clr", 17'h5, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        checkCounters("post_clr", 1, 1, 0, 0, 0, 0);

        req_valid = 1'b1;
        req_tag   = 17'h9;
        req_index = 4'd2;
        req_store = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_resp_valid", resp_valid, 0);
        checkOutput("abort_req_ready",  req_ready,  0);
        checkOutput("abort_init_done",  init_done,  0);
        checkCounters("abort", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst      = 1'b0;
        n        = 0;
        sawResp  = 1'b0;
        sawReady = 1'b0;
        while (!init_done && n < 100) begin
            @(negedge clk);
            n++;
            if (resp_valid) sawResp = 1'b1;
            if (req_ready && !init_done) sawReady = 1'b1;
            if (n == 15) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checkOutput("reinit_cycles", n, 16);
        checkOutput("reinit_no_resp", sawResp, 0);
        checkOutput("reinit_no_ready", sawReady, 0);
        @(negedge clk);
        checkOutput("init_req_ignored", req_ready, 1);

        applyStimulus("reinit_rd",  17'h5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus("reinit_rd2", 17'h9, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        checkCounters("reinit", 2, 0, 0, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
